aes_blk_sched: RTL and testbench

Multi-block sequencer for the AES ECB/CBC core. It latches a job descriptor (mode, direction, key length, key, IV, block count) and then runs the job one block at a time:
- pulls plaintext/ciphertext blocks from a valid/ready input stream;
- drives the core's start and operand buses and waits for the core's result;
- pushes each result to a valid/ready output stream;
- maintains the CBC chaining value between blocks.

It sits between the register interface (sipo/piso) and aes_core. This replaces single-block software polling with a streamed N-block job.

---
 rtl/aes_blk_sched_pkg.sv | 11 +
 rtl/aes_blk_sched_if.sv | 19 +
 rtl/aes_chain_reg.sv | 18 +
 rtl/aes_blk_sched.sv | 118 +++++++++++
 tb/tb_aes_blk_sched.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_blk_sched_pkg.sv
// aes_blk_sched_pkg: shared widths, FSM states and mode constants for the block sequencer
package aes_blk_sched_pkg;
  localparam int SIZE_BLOCK = 128;
  localparam int KEY_LEN = 256;
  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;
  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_ENC = 1'b1;
  typedef enum logic [2:0] {IDLE, FETCH, ARM, WAIT, DRAIN} state_e;
  typedef enum logic [1:0] {CH_HOLD, CH_IV, CH_RES, CH_BLK} chain_sel_e;
endpackage

// File: rtl/aes_blk_sched_if.sv
// aes_blk_sched_if: block streams plus the operand/result bus to the AES core
interface aes_blk_sched_if;
  import aes_blk_sched_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [SIZE_BLOCK-1:0] in_data, out_data;
  logic aes_ecb_cbc, aes_encdec, aes_keylen, aes_start, aes_ready, aes_result_valid;
  logic [KEY_LEN-1:0] aes_key;
  logic [SIZE_BLOCK-1:0] aes_iv, aes_block, aes_result;
  modport master (
    input  in_valid, in_data, out_ready, aes_ready, aes_result_valid, aes_result,
    output in_ready, out_valid, out_data, aes_ecb_cbc, aes_encdec, aes_keylen, aes_key,
           aes_iv, aes_block, aes_start
  );
  modport slave (
    output in_valid, in_data, out_ready, aes_ready, aes_result_valid, aes_result,
    input  in_ready, out_valid, out_data, aes_ecb_cbc, aes_encdec, aes_keylen, aes_key,
           aes_iv, aes_block, aes_start
  );
endinterface

// File: rtl/aes_chain_reg.sv
// aes_chain_reg: CBC chaining value, loaded from the IV or updated from a result or input block
module aes_chain_reg import aes_blk_sched_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  chain_sel_e            sel_i,
  input  logic [SIZE_BLOCK-1:0] iv_i,
  input  logic [SIZE_BLOCK-1:0] res_i,
  input  logic [SIZE_BLOCK-1:0] blk_i,
  output logic [SIZE_BLOCK-1:0] chain_o
);
  logic [SIZE_BLOCK-1:0] chain_d, chain_q;
  always_comb chain_d = sel_i == CH_IV ? iv_i : sel_i == CH_RES ? res_i : sel_i == CH_BLK ? blk_i : chain_q;
  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else chain_q <= chain_d;
  end
  assign chain_o = chain_q;
endmodule

// File: rtl/aes_blk_sched.sv
// aes_blk_sched: runs an N-block ECB/CBC job through a single-block AES core, one block in flight
module aes_blk_sched import aes_blk_sched_pkg::*; #(
  parameter int NB_W = 16,
  parameter int TO_W = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_go,
  input  logic                  cfg_ecb_cbc,
  input  logic                  cfg_encdec,
  input  logic                  cfg_keylen,
  input  logic [KEY_LEN-1:0]    cfg_key,
  input  logic [SIZE_BLOCK-1:0] cfg_iv,
  input  logic [NB_W-1:0]       cfg_nblk,
  aes_blk_sched_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef struct packed {
    state_e                state;
    logic [NB_W-1:0]       rem;
    logic [TO_W-1:0]       to;
    logic                  in_ready;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  start;
    logic                  ecb_cbc;
    logic                  encdec;
    logic                  keylen;
    logic [SIZE_BLOCK-1:0] out_data;
    logic [SIZE_BLOCK-1:0] blk;
    logic [KEY_LEN-1:0]    key;
  } regs_t;
  regs_t r_q, r_d;
  chain_sel_e sel;
  logic [SIZE_BLOCK-1:0] chain;
  logic res_ok;
  aes_chain_reg u_chain (
    .clk(clk), .rst(rst), .sel_i(sel), .iv_i(cfg_iv),
    .res_i(bus.aes_result), .blk_i(r_q.blk), .chain_o(chain)
  );
  // the first WAIT cycle may still see the previous block's held result level
  assign res_ok = bus.aes_result_valid && r_q.to != '0;
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else r_q <= r_d;
  end
  always_comb begin
    r_d = r_q;
    r_d.start = 1'b0;
    sel = CH_HOLD;
    case (r_q.state)
      IDLE: if (cfg_go) begin
        r_d.ecb_cbc = cfg_ecb_cbc;
        r_d.encdec = cfg_encdec;
        r_d.keylen = cfg_keylen;
        r_d.key = cfg_key;
        r_d.rem = cfg_nblk;
        r_d.err = 1'b0;
        r_d.done = cfg_nblk == '0;
        r_d.busy = cfg_nblk != '0;
        r_d.in_ready = cfg_nblk != '0;
        r_d.state = cfg_nblk == '0 ? IDLE : FETCH;
        sel = CH_IV;
      end
      FETCH: if (bus.in_valid && r_q.in_ready) begin
        r_d.blk = bus.in_data;
        r_d.in_ready = 1'b0;
        r_d.state = ARM;
      end
      ARM: if (bus.aes_ready) begin
        r_d.start = 1'b1;
        r_d.to = '0;
        r_d.state = WAIT;
      end
      WAIT: begin
        r_d.to = r_q.to + TO_W'(1);
        if (res_ok) begin
          r_d.out_data = bus.aes_result;
          r_d.out_valid = 1'b1;
          r_d.rem = r_q.rem - NB_W'(1);
          r_d.state = DRAIN;
          sel = r_q.ecb_cbc == MODE_ECB ? CH_HOLD : r_q.encdec == DIR_DEC ? CH_BLK : CH_RES;
        end else if (r_q.to == TO_W'(TIMEOUT - 1)) begin
          r_d.err = 1'b1;
          r_d.busy = 1'b0;
          r_d.out_valid = 1'b0;
          r_d.state = IDLE;
        end
      end
      DRAIN: if (bus.out_ready) begin
        r_d.out_valid = 1'b0;
        r_d.done = r_q.rem == '0;
        r_d.busy = r_q.rem != '0;
        r_d.in_ready = r_q.rem != '0;
        r_d.state = r_q.rem == '0 ? IDLE : FETCH;
      end
      default: r_d.state = IDLE;
    endcase
  end
  assign bus.in_ready = r_q.in_ready;
  assign bus.out_valid = r_q.out_valid;
  assign bus.out_data = r_q.out_data;
  assign bus.aes_ecb_cbc = r_q.ecb_cbc;
  assign bus.aes_encdec = r_q.encdec;
  assign bus.aes_keylen = r_q.keylen;
  assign bus.aes_key = r_q.key;
  assign bus.aes_iv = chain;
  assign bus.aes_block = r_q.blk;
  assign bus.aes_start = r_q.start;
  assign busy = r_q.busy;
  assign done = r_q.done;
  assign err = r_q.err;
endmodule

// File: tb/tb_aes_blk_sched.sv
// tb_aes_blk_sched: directed vectors against a table-driven model of the AES core
module tb_aes_blk_sched;
  import aes_blk_sched_pkg::*;
  localparam int TIMEOUT = 4000;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
  typedef struct { logic [127:0] blk, iv, res; } op_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_go = 1'b0, cfg_ecb_cbc = 1'b0, cfg_encdec = 1'b0, cfg_keylen = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic [15:0] cfg_nblk = '0;
  logic busy, done, err;
  op_t exp_q[$];
  op_t cur;
  logic [255:0] exp_key = '0;
  logic [2:0] exp_mode = '0;
  int checks = 0, errors = 0, starts = 0, cyc = 0, start_cyc = 0, lat = 0;
  bit hang = 1'b0, pend = 1'b0;
  aes_blk_sched_if bus();
  aes_blk_sched #(.NB_W(16), .TO_W(12), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_ecb_cbc(cfg_ecb_cbc), .cfg_encdec(cfg_encdec),
    .cfg_keylen(cfg_keylen), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_nblk(cfg_nblk),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // core model: checks operands at each start, drops the stale result a cycle later, answers after 4 cycles
  initial begin
    bus.aes_ready = 1'b1;
    bus.aes_result_valid = 1'b0;
    bus.aes_result = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        bus.aes_ready = 1'b1;
        bus.aes_result_valid = 1'b0;
      end else if (pend) begin
        bus.aes_result_valid = 1'b0;
        lat--;
        if (lat == 0) begin
          pend = 1'b0;
          bus.aes_ready = 1'b1;
          bus.aes_result_valid = !hang;
          bus.aes_result = cur.res;
        end
      end
      if (!rst && bus.aes_start) begin
        starts++;
        start_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL core_start: unexpected aes_start with block %h", bus.aes_block);
          cur = '{'0, '0, '0};
        end else begin
          cur = exp_q.pop_front();
          if ({bus.aes_block, bus.aes_iv} !== {cur.blk, cur.iv}) begin
            errors++;
            $display("FAIL core_op: blk=%h iv=%h, required blk=%h iv=%h", bus.aes_block, bus.aes_iv, cur.blk, cur.iv);
          end
        end
        checks++;
        if (bus.aes_key !== exp_key || {bus.aes_ecb_cbc, bus.aes_encdec, bus.aes_keylen} !== exp_mode) begin
          errors++;
          $display("FAIL core_cfg: key=%h mode=%b, required key=%h mode=%b", bus.aes_key,
                   {bus.aes_ecb_cbc, bus.aes_encdec, bus.aes_keylen}, exp_key, exp_mode);
        end
        pend = 1'b1;
        lat = 4;
        bus.aes_ready = 1'b0;
      end
    end
  end
  task automatic go(input logic ecb, input logic enc, input logic kl, input logic [255:0] key,
                    input logic [127:0] iv, input logic [15:0] n);
    @(negedge clk);
    cfg_ecb_cbc = ecb;
    cfg_encdec = enc;
    cfg_keylen = kl;
    cfg_key = key;
    cfg_iv = iv;
    cfg_nblk = n;
    exp_key = key;
    exp_mode = {ecb, enc, kl};
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
  endtask
  task automatic send(input logic [127:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic recv(input logic [127:0] exp, input string name, input int hold);
    int n = 0;
    int s0;
    logic [127:0] d0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, n);
    end
    d0 = bus.out_data;
    s0 = starts;
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.in_ready !== 1'b0 || starts != s0) begin
        errors++;
        $display("FAIL %s_hold: valid=%b data=%h in_ready=%b starts=%0d, required 1 %h 0 %0d",
                 name, bus.out_valid, bus.out_data, bus.in_ready, starts, d0, s0);
      end
    end
    checks++;
    if (bus.out_data !== exp) begin
      errors++;
      $display("FAIL %s_data: out_data=%h, required %h", name, bus.out_data, exp);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic check_done(input string name);
    checks++;
    if ({done, busy, err} !== 3'b100) begin
      errors++;
      $display("FAIL %s_done: done/busy/err=%b, required 100", name, {done, busy, err});
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, busy, done, err, bus.aes_start} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: %b, required 000000", {bus.in_ready, bus.out_valid, busy, done, err, bus.aes_start});
    end
    checks++;
    if ({bus.out_data, bus.aes_iv, bus.aes_block} !== '0 || bus.aes_key !== '0) begin
      errors++;
      $display("FAIL reset_data: out=%h iv=%h blk=%h, required 0", bus.out_data, bus.aes_iv, bus.aes_block);
    end
    rst = 1'b0;
  endtask
  task automatic test_ecb();
    exp_q.push_back('{128'h00112233445566778899aabbccddeeff, '0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a});
    go(MODE_ECB, DIR_ENC, 1'b0, K128, '0, 16'd1);
    checks++;
    if ({busy, done, bus.in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL ecb_start: busy/done/in_ready=%b, required 101", {busy, done, bus.in_ready});
    end
    send(128'h00112233445566778899aabbccddeeff);
    recv(128'h69c4e0d86a7b0430d8cdb78070b4c55a, "ecb", 0);
    check_done("ecb");
  endtask
  task automatic test_cbc_enc();
    exp_q.push_back('{P1, IV, C1});
    exp_q.push_back('{P2, C1, C2});
    go(MODE_CBC, DIR_ENC, 1'b0, K2, IV, 16'd2);
    send(P1);
    recv(C1, "cbc_enc0", 0);
    send(P2);
    recv(C2, "cbc_enc1", 0);
    check_done("cbc_enc");
  endtask
  task automatic test_cbc_dec();
    exp_q.push_back('{C1, IV, P1});
    exp_q.push_back('{C2, C1, P2});
    go(MODE_CBC, DIR_DEC, 1'b0, K2, IV, 16'd2);
    send(C1);
    recv(P1, "cbc_dec0", 0);
    send(C2);
    recv(P2, "cbc_dec1", 0);
    check_done("cbc_dec");
  endtask
  task automatic test_back_to_back();
    logic [127:0] i0 = 128'h0f0e0d0c0b0a09080706050403020100;
    logic [127:0] r0 = {4{32'h12345678}};
    logic [127:0] r1 = {4{32'h9abcdef0}};
    logic [127:0] r2 = {4{32'h0badf00d}};
    int s0 = starts;
    exp_q.push_back('{{4{32'ha0a0a0a0}}, i0, r0});
    exp_q.push_back('{{4{32'hb1b1b1b1}}, r0, r1});
    exp_q.push_back('{{4{32'hc2c2c2c2}}, r1, r2});
    go(MODE_CBC, DIR_ENC, 1'b1, {8{32'hdeadbeef}}, i0, 16'd3);
    send({4{32'ha0a0a0a0}});
    recv(r0, "bp0", 50);
    send({4{32'hb1b1b1b1}});
    recv(r1, "bp1", 0);
    send({4{32'hc2c2c2c2}});
    recv(r2, "bp2", 0);
    check_done("bp");
    checks++;
    if (starts != s0 + 3) begin
      errors++;
      $display("FAIL bp_starts: %0d starts, required 3", starts - s0);
    end
  endtask
  task automatic test_timeout();
    int n = 0;
    int s0;
    hang = 1'b1;
    exp_q.push_back('{{4{32'h11111111}}, '0, '0});
    go(MODE_ECB, DIR_ENC, 1'b0, K128, '0, 16'd1);
    s0 = starts;
    send({4{32'h11111111}});
    while (!err && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err !== 1'b1 || cyc - start_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL timeout: err=%b after %0d cycles, required 1 after %0d", err, cyc - start_cyc, TIMEOUT);
    end
    checks++;
    if ({busy, bus.in_ready, bus.out_valid} !== 3'b000 || starts != s0 + 1) begin
      errors++;
      $display("FAIL timeout_idle: busy/in_ready/out_valid=%b starts=%0d, required 000 %0d",
               {busy, bus.in_ready, bus.out_valid}, starts, s0 + 1);
    end
    hang = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back('{{4{32'h22222222}}, '0, {4{32'h33333333}}});
    go(MODE_ECB, DIR_DEC, 1'b0, K128, '0, 16'd1);
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_clear: err/busy=%b, required 01", {err, busy});
    end
    send({4{32'h22222222}});
    recv({4{32'h33333333}}, "after_to", 0);
    check_done("after_to");
  endtask
  task automatic test_rst_mid_wait();
    int n = 0;
    int s0;
    logic [255:0] k = {8{32'h01234567}};
    logic [127:0] iv = {4{32'h89abcdef}};
    exp_q.push_back('{{4{32'h44444444}}, iv, {4{32'h55555555}}});
    go(MODE_CBC, DIR_ENC, 1'b1, k, iv, 16'd2);
    s0 = starts;
    send({4{32'h44444444}});
    while (starts == s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (starts == s0) begin
      errors++;
      $display("FAIL rst_start: no aes_start after %0d cycles, required one", n);
    end
    cfg_key = ~k;
    cfg_iv = '0;
    cfg_nblk = 16'd5;
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 0;
    checks++;
    if (busy !== 1'b1 || bus.aes_key !== k || bus.aes_iv !== iv) begin
      errors++;
      $display("FAIL busy_go: busy=%b key=%h iv=%h, required 1 %h %h", busy, bus.aes_key, bus.aes_iv, k, iv);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, busy, done, err, bus.aes_start, bus.aes_ecb_cbc, bus.aes_keylen} !== 8'b0) begin
      errors++;
      $display("FAIL rst_flags: %b, required 00000000",
               {bus.in_ready, bus.out_valid, busy, done, err, bus.aes_start, bus.aes_ecb_cbc, bus.aes_keylen});
    end
    checks++;
    if ({bus.out_data, bus.aes_iv, bus.aes_block} !== '0 || bus.aes_key !== '0) begin
      errors++;
      $display("FAIL rst_data: iv=%h blk=%h key=%h, required 0", bus.aes_iv, bus.aes_block, bus.aes_key);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic test_zero_blocks();
    int s0 = starts;
    go(MODE_ECB, DIR_ENC, 1'b0, K128, '0, 16'd0);
    checks++;
    if ({done, busy, bus.in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL zero_done: done/busy/in_ready=%b, required 100", {done, busy, bus.in_ready});
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || done !== 1'b1 || starts != s0) begin
        errors++;
        $display("FAIL zero_quiet: in_ready=%b done=%b starts=%0d, required 0 1 %0d", bus.in_ready, done, starts, s0);
      end
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ecb();
    test_cbc_enc();
    test_cbc_dec();
    test_back_to_back();
    test_timeout();
    test_rst_mid_wait();
    test_zero_blocks();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
